ex_muldiv: RTL and testbench

//   Multi-cycle RV32M multiply/divide unit, instantiated beside the ex stage.
//   - Accepts one MUL/DIV/REM operation at a time, runs it iteratively and

---
 rtl/ex_muldiv.sv | 207 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv -- iterative RV32M multiply/divide unit beside the ex stage.
//
// One MUL/DIV/REM operation at a time. Operands are reduced to magnitudes on
// issue; multiply runs radix-2 shift-add, divide runs restoring division, one
// bit per clock for XLEN clocks. The sign fix-up is applied on the last
// iteration, and the result is registered on entry to DONE. Divide by zero
// and signed overflow skip the iteration and go straight to DONE.
//
// Optional build macro:
//   EX_MULDIV_FAST_MUL_EN  MUL* ops use one combinational XLEN x XLEN multiply
//                          and finish with single-cycle latency. Divide is
//                          unchanged. When the macro is undefined, no '*'
//                          operator is used.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   start_i      issue an operation (accepted in IDLE and DONE)
//   op_i         funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   op1_i/op2_i  rs1 / rs2 values
//   reg_waddr_i  destination register of the issued operation
//   kill_i       abandon any operation; overrides start_i
//   busy_o       high while iterating (CALC)
//   ready_o      one-cycle pulse: result_o / reg_waddr_o valid
//   result_o     result, held until the next completion or reset
//   reg_waddr_o  destination of result_o
// ----------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       op1_i,
    input  logic [XLEN-1:0]       op2_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  kill_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [XLEN-1:0]       result_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q;
    logic [2:0]            op_q;
    logic [XLEN-1:0]       mag_q;      // multiplicand (mul) or divisor (div)
    logic [XLEN-1:0]       hi_q;       // product high half / partial remainder
    logic [XLEN-1:0]       lo_q;       // multiplier bits / dividend -> quotient
    logic                  neg_quo_q;  // product or quotient must be negated
    logic                  neg_rem_q;  // remainder must be negated
    logic [CNT_W-1:0]      cnt_q;
    logic [REG_ADDR_W-1:0] waddr_pend_q;
    logic                  busy_q;
    logic                  ready_q;
    logic [XLEN-1:0]       result_q;
    logic [REG_ADDR_W-1:0] reg_waddr_q;

    // ---------------- issue-side decode ----------------
    logic            op1_signed, op2_signed, s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, special_hit;
    logic [XLEN-1:0] special_res;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        op1_signed  = (op_i == 3'b001) || (op_i == 3'b010) ||
                      (op_i == 3'b100) || (op_i == 3'b110);
        op2_signed  = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        s1          = op1_signed & op1_i[XLEN-1];
        s2          = op2_signed & op2_i[XLEN-1];
        mag1        = s1 ? (~op1_i + 1'b1) : op1_i;
        mag2        = s2 ? (~op2_i + 1'b1) : op2_i;
        div_zero    = (op2_i == '0);
        // Only the signed ops can overflow: MIN / -1
        div_ovf     = ~op_i[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
        special_hit = op_i[2] & (div_zero | div_ovf);
        // op_i[1] selects remainder among the divide ops
        if (div_zero) special_res = op_i[1] ? op1_i : '1;
        else          special_res = op_i[1] ? '0 : op1_i;
    end

`ifdef EX_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_prod_s;
    always_comb begin
        fast_prod   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        fast_prod_s = (s1 ^ s2) ? (~fast_prod + 1'b1) : fast_prod;
        fast_hit    = ~op_i[2];
        fast_res    = (op_i[1:0] == 2'b00) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
    end
`else
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
    end
`endif

    // ---------------- one iteration + final fix-up ----------------
    logic [XLEN:0]     mul_sum, div_tr, div_diff;
    logic              div_ok;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, calc_res;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_tr   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_tr - {1'b0, mag_q};
        div_ok   = ~div_diff[XLEN];        // no borrow: divisor fits
        if (op_q[2]) begin
            hi_d = div_ok ? div_diff[XLEN-1:0] : div_tr[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ok};
        end else begin
            // add-then-shift: carry enters the top of the accumulator
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {hi_d, lo_d};
        prod_s   = neg_quo_q ? (~prod + 1'b1) : prod;
        quo_s    = neg_quo_q ? (~lo_d + 1'b1) : lo_d;
        rem_s    = neg_rem_q ? (~hi_d + 1'b1) : hi_d;
        if (op_q[2])                calc_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00) calc_res = prod_s[XLEN-1:0];
        else                         calc_res = prod_s[2*XLEN-1:XLEN];
    end

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            mag_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            cnt_q        <= '0;
            waddr_pend_q <= '0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            result_q     <= '0;
            reg_waddr_q  <= '0;
        end else if (kill_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        op_q         <= op_i;
                        hi_q         <= '0;
                        lo_q         <= op_i[2] ? mag1 : mag2;
                        mag_q        <= op_i[2] ? mag2 : mag1;
                        neg_quo_q    <= s1 ^ s2;
                        neg_rem_q    <= s1;
                        cnt_q        <= '0;
                        waddr_pend_q <= reg_waddr_i;
                        if (special_hit || fast_hit) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            ready_q     <= 1'b1;
                            result_q    <= special_hit ? special_res : fast_res;
                            reg_waddr_q <= reg_waddr_i;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                        result_q    <= calc_res;
                        reg_waddr_q <= waddr_pend_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign result_o    = result_q;
    assign reg_waddr_o = reg_waddr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv (XLEN=32). The driver pushes expected
// result, destination and latency for each issued op; a monitor pops and
// compares on every ready_o pulse. Random ops use a plain-arithmetic model.
module tb_ex_muldiv;
    localparam int XLEN = 32;
    localparam int AW   = 5;
`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] op1_i, op2_i;
    logic [AW-1:0]   reg_waddr_i;
    logic            kill_i;
    logic            busy_o, ready_o;
    logic [XLEN-1:0] result_o;
    logic [AW-1:0]   reg_waddr_o;

    ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .op1_i(op1_i), .op2_i(op2_i), .reg_waddr_i(reg_waddr_i),
        .kill_i(kill_i), .busy_o(busy_o), .ready_o(ready_o),
        .result_o(result_o), .reg_waddr_o(reg_waddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        int unsigned issue;
        int unsigned lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the RV32M definitions
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb_, q;
        logic [63:0] ua, ub, p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        p   = '0;
        case (op)
            3'd0: begin p = ua * ub;              return p[31:0];  end
            3'd1: begin p = sa * sb_;             return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);    return p[63:32]; end
            3'd3: begin p = ua * ub;              return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return a;
                q = sa / sb_; p = q; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb_; p = q; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Monitor: compare on each ready pulse, track busy run length
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready_o) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got result 0x%0h waddr %0d, required no ready", result_o, reg_waddr_o);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, 64'(result_o), 64'(e.res));
                    chk({e.name, "_waddr"}, 64'(reg_waddr_o), 64'(e.wa));
                    chk({e.name, "_latency"}, 64'(cyc - e.issue), 64'(e.lat));
                    chk({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat - 1));
                    $display("op %-16s res=0x%08h waddr=%0d lat=%0d", e.name, result_o, reg_waddr_o, cyc - e.issue);
                end
                busy_cnt = 0;
            end else if (busy_o) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge; returns at the following negedge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input bit push, input logic [31:0] expv, input string nm);
        exp_t e;
        start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; reg_waddr_i = wa;
        if (push) begin
            e.res = expv; e.wa = wa; e.issue = cyc; e.lat = lat_of(op, a, b); e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Leaves the bench at the negedge inside the DONE cycle
    task automatic wait_ready(input string nm);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (ready_o) seen = 1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no ready in 200 cycles, required ready", nm);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] expv, input string nm);
        issue(op, a, b, wa, 1'b1, expv, nm);
        wait_ready(nm);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rwa;
        string       nms [8];
        nms = '{"mul", "mulh", "mulhsu", "mulhu", "div", "divu", "rem", "remu"};

        rst = 1'b0; start_i = 1'b0; kill_i = 1'b0;
        op_i = '0; op1_i = '0; op2_i = '0; reg_waddr_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", 64'(result_o), 64'd0);
        chk("reset_waddr", 64'(reg_waddr_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases (back-to-back from DONE)
        run(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd1, 32'hFFFF_FFFD, "div_neg");
        run(3'd6, 32'hFFFF_FFF9, 32'h2, 5'd2, 32'hFFFF_FFFF, "rem_neg");
        run(3'd5, 32'h1234, 32'h0, 5'd3, 32'hFFFF_FFFF, "divu_zero");
        run(3'd7, 32'h1234, 32'h0, 5'd4, 32'h1234, "remu_zero");
        run(3'd4, MIN, 32'hFFFF_FFFF, 5'd5, MIN, "div_ovf");
        run(3'd6, MIN, 32'hFFFF_FFFF, 5'd6, 32'h0, "rem_ovf");
        run(3'd1, MIN, MIN, 5'd8, 32'h4000_0000, "mulh_min");
        run(3'd3, MIN, MIN, 5'd9, 32'h4000_0000, "mulhu_min");
        run(3'd0, MIN, MIN, 5'd10, 32'h0, "mul_min");
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF, "mulhsu_m1");
        @(negedge clk);

        // Kill 10 cycles into a DIV
        issue(3'd4, 32'd100, 32'd3, 5'd12, 1'b0, 32'h0, "killed");
        repeat (9) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("kill_busy", 64'(busy_o), 64'd0);
        chk("kill_ready", 64'(ready_o), 64'd0);
        // Kill and start together in IDLE: kill wins
        kill_i = 1'b1;
        issue(3'd4, 32'd100, 32'd3, 5'd13, 1'b0, 32'h0, "kill_vs_start");
        kill_i = 1'b0;
        chk("kill_start_busy", 64'(busy_o), 64'd0);
        chk("kill_start_ready", 64'(ready_o), 64'd0);
        run(3'd4, 32'd1000, 32'd7, 5'd7, 32'd142, "div_after_kill");
        @(negedge clk);

        // start while busy is ignored
        issue(3'd5, 32'd100, 32'd9, 5'd10, 1'b1, 32'd11, "divu_first");
        repeat (5) @(negedge clk);
        issue(3'd0, 32'd7, 32'd7, 5'd11, 1'b0, 32'h0, "ignored");
        wait_ready("divu_first");
        repeat (40) @(negedge clk);

        // Reset mid-CALC
        issue(3'd7, 32'd12345, 32'd100, 5'd12, 1'b0, 32'h0, "reset_mid");
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_result", 64'(result_o), 64'd0);
        chk("midrst_waddr", 64'(reg_waddr_o), 64'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            rwa = 5'($urandom);
            run(rop, ra, rb, rwa, ref_model(rop, ra, rb), nms[rop]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
